wshb_pattern_writer: RTL and testbench
======================================

WSHB_PATTERN_WRITER -- requirements
Module: wshb_pattern_writer

Interface
REQ-001 SHALL have parameters: HDISP 800, frame width in pixels; VDISP 480, frame height in lines; BURST_LEN 64, beats per bus tenure; BASE_ADR 0, byte address of pixel (0,0).
REQ-002 SHALL have ports, one per line:
  sys_clk  in  1  system clock; sys_rst, asynchronous, active-high, applies to it
  sys_rst  in  1  asynchronous active-high reset
  run  in  1  enables frame writing
  cyc  out  1  Wishbone cycle
  stb  out  1  Wishbone strobe
  we  out  1  write enable
  adr  out  32  byte address
  dat_ms  out  32  write data, 0x00RRGGBB
  sel  out  4  byte selects
  cti  out  3  cycle type
  bte  out  2  burst type
  ack  in  1  slave acknowledge
  err  in  1  slave error
  rty  in  1  slave retry
  dat_sm  in  32  read data, ignored
  frame_done  out  1  one-cycle pulse when a frame completes
  err_flag  out  1  sticky bus-error indicator

Function
REQ-003 SHALL use fixed outputs: we=1 in WRITE state, else 0; sel=4'hF; cti=3'b000 (classic); bte=2'b00.
REQ-004 SHALL implement states IDLE, WRITE and YIELD.
REQ-005 IDLE: cyc=stb=0; if run=1, go to WRITE on the next edge.
REQ-006 WRITE: cyc=stb=1.
  - adr = BASE_ADR + 4*(y*HDISP + x); dat_ms = pattern(x,y).
  - Both outputs are registered and stay stable until a termination.
REQ-007 A beat SHALL terminate on the edge where ack=1 or err=1.
  - On that edge: x increments; at x=HDISP-1, x wraps to 0 and y increments; at y=VDISP-1, y wraps to 0.
  - adr and dat_ms update for the new (x,y) in the same cycle.
  - stb stays high, so a combinational-ack slave gets one beat per cycle.
REQ-008 rty=1 without ack/err SHALL hold the same beat; x, y, adr and dat_ms do not change.
REQ-009 err=1 SHALL set err_flag and advance as for ack; err has priority over ack and rty.
REQ-010 The beat counter SHALL count terminated beats. After the BURST_LEN-th beat, go to YIELD.
REQ-011 YIELD SHALL last exactly one cycle with cyc=stb=0, letting other masters win arbitration.
  - Then go to WRITE if run=1, else to IDLE.
  - The beat counter clears on entry to YIELD.
REQ-012 When the beat at (HDISP-1, VDISP-1) terminates:
  - frame_done SHALL pulse high for the following single cycle.
  - The FSM SHALL go to YIELD even if the beat count is below BURST_LEN.
  - If burst end and frame end coincide, there SHALL be only one YIELD cycle.
REQ-013 run=0 in WRITE SHALL take effect only at the next YIELD; (x,y) is kept, and writing resumes from that position when run returns to 1.
REQ-014 The x and y counters SHALL be $clog2(HDISP) and $clog2(VDISP) bits wide. Address arithmetic SHALL be 32-bit unsigned and wrap modulo 2^32.

Reset
REQ-015 sys_rst=1 SHALL force, immediately and asynchronously: cyc=stb=we=0, adr=0, dat_ms=0, frame_done=0, err_flag=0, x=y=0, beat counter=0, state=IDLE.
REQ-016 Reset mid-beat SHALL abandon the beat. After release, writing restarts at pixel (0,0).
REQ-017 err_flag SHALL clear only on reset.

Configuration
REQ-018 Macro GRID_PATTERN_EN.
  - Defined: pattern = 0x00FFFFFF when x[3:0]==0 or y[3:0]==0, else 0x00000000 (16-pixel white grid).
  - Undefined: pattern = {8'h00, x[7:0], y[7:0], 8'h00} (red/green gradient).

Verification
REQ-019 Every scenario uses HDISP=4, VDISP=2, BURST_LEN=3, BASE_ADR=0, with the slave acking combinationally.
REQ-020 Scenarios:
  - Reset, then run=1 -> cyc stays 0 for 1 cycle; then adr 0x0, 0x4, 0x8 on consecutive cycles; then cyc=0 for exactly 1 cycle; then adr 0xC.
  - Full frame -> 8 beats ending at adr 0x1C; frame_done high exactly 1 cycle, in the YIELD after beat 8; next beat adr 0x0.
  - rty=1 for 3 cycles on the adr 0x4 beat -> adr and dat_ms stay 0x4 and unchanged; advances to 0x8 after ack.
  - err=1 on the adr 0x8 beat -> err_flag=1 from the next cycle, next adr 0xC; err_flag stays 1 until sys_rst.
  - run=0 during the 2nd beat -> beat 3 still issued; YIELD then IDLE; run=1 later resumes at adr 0xC.
  - sys_rst asserted mid-beat -> cyc, stb, adr and frame_done are 0 asynchronously; after release, first adr is 0x0.
  - With GRID_PATTERN_EN: pixel (1,1) data = 0x00000000 and (0,1) = 0x00FFFFFF. Without it: (3,1) = 0x00030100.

Source files
------------

// File: rtl/wshb_pattern_writer.sv
// Wishbone classic-cycle master that streams a test pattern into a frame buffer in bursts.
// Define GRID_PATTERN_EN for a 16-pixel white grid; the default build emits a red/green gradient.
module wshb_pattern_writer #(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter int          BURST_LEN = 64,
    parameter logic [31:0] BASE_ADR  = 32'h0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        run,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    input  logic [31:0] dat_sm,
    output logic        frame_done,
    output logic        err_flag
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, WRITE, YIELD} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic            wr_q, wr_d;
    logic            frame_done_q, frame_done_d;
    logic            err_flag_q, err_flag_d;

    logic            term;
    logic            last_x;
    logic            last_y;
    logic            unused_inputs;

    function automatic logic [31:0] pixel_adr(input logic [XW-1:0] px, input logic [YW-1:0] py);
        logic [31:0] lin;
        lin = 32'(py) * 32'(HDISP) + 32'(px);
        return BASE_ADR + (lin << 2);
    endfunction

    function automatic logic [31:0] pattern(input logic [XW-1:0] px, input logic [YW-1:0] py);
        logic [31:0] xe;
        logic [31:0] ye;
        xe = 32'(px);
        ye = 32'(py);
`ifdef GRID_PATTERN_EN
        return (xe[3:0] == 4'h0 || ye[3:0] == 4'h0) ? 32'h00FF_FFFF : 32'h0000_0000;
`else
        return {8'h00, xe[7:0], ye[7:0], 8'h00};
`endif
    endfunction

    // rty needs no logic of its own: a beat without ack/err simply holds
    assign unused_inputs = ^{dat_sm, rty};

    assign term   = (state_q == WRITE) && (ack || err);
    assign last_x = (x_q == XW'(HDISP - 1));
    assign last_y = (y_q == YW'(VDISP - 1));

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        beat_d       = beat_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        frame_done_d = 1'b0;
        err_flag_d   = err_flag_q;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (term) begin
                    if (err) begin
                        err_flag_d = 1'b1;
                    end
                    if (last_x) begin
                        x_d = '0;
                        y_d = last_y ? '0 : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    frame_done_d = last_x && last_y;
                    // Frame end forces the yield; coinciding with burst end still gives one YIELD
                    if (beat_q == BW'(BURST_LEN - 1) || (last_x && last_y)) begin
                        state_d = YIELD;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            YIELD: begin
                state_d = run ? WRITE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == WRITE) begin
            adr_d = pixel_adr(x_d, y_d);
            dat_d = pattern(x_d, y_d);
        end
        wr_d = (state_d == WRITE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            beat_q       <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
            wr_q         <= 1'b0;
            frame_done_q <= 1'b0;
            err_flag_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            beat_q       <= beat_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            wr_q         <= wr_d;
            frame_done_q <= frame_done_d;
            err_flag_q   <= err_flag_d;
        end
    end

    assign cyc        = wr_q;
    assign stb        = wr_q;
    assign we         = wr_q;
    assign adr        = adr_q;
    assign dat_ms     = dat_q;
    assign sel        = 4'hF;
    assign cti        = 3'b000;
    assign bte        = 2'b00;
    assign frame_done = frame_done_q;
    assign err_flag   = err_flag_q;

endmodule

// File: tb/tb_wshb_pattern_writer.sv
// Bench for wshb_pattern_writer on a 4x2 frame with 3-beat bursts and a combinational-ack slave.
// Expected bus activity comes from a pixel-index model plus fixed address tables.
module tb_wshb_pattern_writer;

    localparam int HD    = 4;
    localparam int VD    = 2;
    localparam int BL    = 3;
    localparam int NPIX  = HD * VD;
    localparam int MODE_IDLE  = 0;
    localparam int MODE_WRITE = 1;
    localparam int MODE_GAP   = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        run     = 1'b0;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_ms, dat_sm;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err, rty;
    logic        frame_done, err_flag;
    logic        ackReq = 1'b0;
    logic        errReq = 1'b0;
    logic        rtyReq = 1'b0;

    int checks = 0;
    int errors = 0;

    int mMode;
    int mPix;
    int mBeats;
    bit mErr;
    bit mDone;

    logic [31:0] histAdr[$];
    logic [31:0] histDat[$];
    logic [31:0] histCyc[$];
    logic [31:0] histDone[$];
    logic [31:0] histErr[$];

    assign ack    = stb & ackReq;
    assign err    = stb & errReq;
    assign rty    = stb & rtyReq;
    assign dat_sm = 32'hDEAD_BEEF;

    always #5 sys_clk = ~sys_clk;

    wshb_pattern_writer #(
        .HDISP(HD), .VDISP(VD), .BURST_LEN(BL), .BASE_ADR(32'h0)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run),
        .cyc(cyc), .stb(stb), .we(we), .adr(adr), .dat_ms(dat_ms),
        .sel(sel), .cti(cti), .bte(bte),
        .ack(ack), .err(err), .rty(rty), .dat_sm(dat_sm),
        .frame_done(frame_done), .err_flag(err_flag)
    );

    function automatic logic [31:0] modelPattern(input int pix);
        int px;
        int py;
        px = pix % HD;
        py = pix / HD;
`ifdef GRID_PATTERN_EN
        return ((px % 16) == 0 || (py % 16) == 0) ? 32'h00FF_FFFF : 32'h0;
`else
        return 32'((px % 256) * 65536 + (py % 256) * 256);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mMode  = MODE_IDLE;
        mPix   = 0;
        mBeats = 0;
        mErr   = 1'b0;
        mDone  = 1'b0;
        histAdr.delete();
        histDat.delete();
        histCyc.delete();
        histDone.delete();
        histErr.delete();
    endtask

    // Called at a falling edge: check this cycle, drive inputs, advance the model one cycle
    task automatic applyStimulus(input bit runIn, input int kind);
        bit writing;
        bit doAck;
        bit doErr;
        writing = (mMode == MODE_WRITE);
        checkOutput("cyc", 32'(cyc), 32'(writing));
        checkOutput("stb", 32'(stb), 32'(writing));
        checkOutput("we", 32'(we), 32'(writing));
        checkOutput("frame_done", 32'(frame_done), 32'(mDone));
        checkOutput("err_flag", 32'(err_flag), 32'(mErr));
        checkOutput("sel_cti_bte", {23'd0, sel, cti, bte}, {23'd0, 4'hF, 3'b000, 2'b00});
        if (writing) begin
            checkOutput("adr", adr, 32'(4 * mPix));
            checkOutput("dat_ms", dat_ms, modelPattern(mPix));
        end
        histAdr.push_back(adr);
        histDat.push_back(dat_ms);
        histCyc.push_back(32'(cyc));
        histDone.push_back(32'(frame_done));
        histErr.push_back(32'(err_flag));

        doAck  = (kind == 1 || kind == 4 || kind == 5);
        doErr  = (kind == 3 || kind == 5);
        run    = runIn;
        ackReq = doAck;
        errReq = doErr;
        rtyReq = (kind == 2 || kind == 4);

        mDone = 1'b0;
        case (mMode)
            MODE_IDLE: if (runIn) mMode = MODE_WRITE;
            MODE_WRITE: begin
                if (doAck || doErr) begin
                    if (doErr) mErr = 1'b1;
                    mBeats++;
                    if (mPix == NPIX - 1) begin
                        mDone  = 1'b1;
                        mPix   = 0;
                        mMode  = MODE_GAP;
                        mBeats = 0;
                    end else begin
                        mPix++;
                        if (mBeats == BL) begin
                            mMode  = MODE_GAP;
                            mBeats = 0;
                        end
                    end
                end
            end
            default: mMode = runIn ? MODE_WRITE : MODE_IDLE;
        endcase
        @(negedge sys_clk);
    endtask

    task automatic finishReset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        modelReset();
    endtask

    task automatic resetDut();
        run    = 1'b0;
        ackReq = 1'b0;
        errReq = 1'b0;
        rtyReq = 1'b0;
        sys_rst = 1'b0;
        #1;
        sys_rst = 1'b1;
        #1;
        checkOutput("rst_cyc", 32'(cyc), 32'd0);
        checkOutput("rst_stb_we", 32'({stb, we}), 32'd0);
        checkOutput("rst_adr", adr, 32'd0);
        checkOutput("rst_dat", dat_ms, 32'd0);
        checkOutput("rst_flags", 32'({frame_done, err_flag}), 32'd0);
        finishReset();
    endtask

    // Assert reset between clock edges while a beat is outstanding
    task automatic midBeatReset();
        checkOutput("pre_rst_cyc", 32'(cyc), 32'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        checkOutput("async_cyc", 32'(cyc), 32'd0);
        checkOutput("async_stb", 32'(stb), 32'd0);
        checkOutput("async_adr", adr, 32'd0);
        checkOutput("async_frame_done", 32'(frame_done), 32'd0);
        run    = 1'b0;
        ackReq = 1'b0;
        errReq = 1'b0;
        rtyReq = 1'b0;
        finishReset();
    endtask

    initial begin
        int expCyc[13];
        int expAdr[13];
        int s2Kind[11];
        bit s4Run[8];
        expCyc = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 1};
        expAdr = '{0, 32'h0, 32'h4, 32'h8, 0, 32'hC, 32'h10, 32'h14, 0, 32'h18, 32'h1C, 0, 32'h0};
        s2Kind = '{1, 1, 2, 2, 2, 1, 3, 1, 1, 1, 1};
        s4Run  = '{1, 1, 0, 0, 0, 0, 1, 1};

        modelReset();
        resetDut();

        // Bursts of three, yields between them, full frame and wrap to pixel 0
        for (int i = 0; i < 13; i++) applyStimulus(1'b1, 1);
        for (int i = 0; i < 13; i++) begin
            checkOutput($sformatf("s1_cyc%0d", i), histCyc[i], 32'(expCyc[i]));
            if (expCyc[i] == 1) checkOutput($sformatf("s1_adr%0d", i), histAdr[i], 32'(expAdr[i]));
        end
        checkOutput("s1_done_before", histDone[10], 32'd0);
        checkOutput("s1_done_yield", histDone[11], 32'd1);
        checkOutput("s1_done_after", histDone[12], 32'd0);
`ifdef GRID_PATTERN_EN
        checkOutput("s1_dat_1_1", histDat[7], 32'h0000_0000);
        checkOutput("s1_dat_0_1", histDat[6], 32'h00FF_FFFF);
`else
        checkOutput("s1_dat_3_1", histDat[10], 32'h0003_0100);
`endif

        // Retry holds the beat, then error advances and sets the sticky flag
        resetDut();
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, s2Kind[i]);
        for (int i = 2; i < 6; i++) begin
            checkOutput($sformatf("s2_rty_adr%0d", i), histAdr[i], 32'h4);
            checkOutput($sformatf("s2_rty_dat%0d", i), histDat[i], histDat[2]);
        end
        checkOutput("s2_adr_after_ack", histAdr[6], 32'h8);
        checkOutput("s2_errflag_before", histErr[6], 32'd0);
        checkOutput("s2_errflag_after", histErr[7], 32'd1);
        checkOutput("s2_adr_after_err", histAdr[8], 32'hC);
        checkOutput("s2_errflag_sticky", histErr[10], 32'd1);

        // run dropped during the second beat: burst completes, then idle, then resume
        resetDut();
        for (int i = 0; i < 8; i++) applyStimulus(s4Run[i], 1);
        checkOutput("s4_beat3_cyc", histCyc[3], 32'd1);
        checkOutput("s4_beat3_adr", histAdr[3], 32'h8);
        checkOutput("s4_idle_cyc", histCyc[4] | histCyc[5] | histCyc[6], 32'd0);
        checkOutput("s4_resume_adr", histAdr[7], 32'hC);

        midBeatReset();
        applyStimulus(1'b1, 1);
        applyStimulus(1'b1, 1);
        checkOutput("s5_restart_adr", histAdr[1], 32'h0);

        // Randomised run/ack/err/rty mix against the model
        for (int i = 0; i < 400; i++) begin
            if (i == 200) resetDut();
            applyStimulus($urandom_range(0, 9) != 0, int'($urandom_range(0, 5)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
